// File: rtl/lc3_control_fsm.sv
// LC-3 control sequencer: fetch / decode / execute FSM that drives every
// datapath load, bus gate, mux select, ALU op and SRAM strobe. Memory
// states are stretched to MEM_WAIT cycles by a small wait counter.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2  // 1..7 cycles per SRAM access
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic [1:0]  ADDR2MUX,
  output logic        ADDR1MUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, PAUSE_IR1, PAUSE_IR2, S32,
    S1, S5, S9, S0, S22, S12, S4, S21, S20,
    S6, S25, S27, S7, S23, S16, PAUSE1, PAUSE2
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       wait_done;

  // Only opcode, IR[11] (JSR mode) and IR[5] (immediate select) steer control.
  logic ir_unused;
  assign ir_unused = ^{IR[10:6], IR[4:0]};

  assign wait_done = (wait_cnt_q == WAIT_LAST);

  // State and wait-counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= HALTED;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; the wait counter idles at zero so each memory state
  // is entered with a cleared count and stops at WAIT_LAST.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      HALTED:    if (Run) state_d = S18;
      S18:       state_d = S33;
      S33:       if (wait_done) state_d = S35; else wait_cnt_d = wait_cnt_q + 3'd1;
      S35:       state_d = PAUSE_IR1;
      PAUSE_IR1: if (Continue) state_d = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) state_d = S32;
      S32: begin
        case (IR[15:12])
          4'b0001: state_d = S1;
          4'b0101: state_d = S5;
          4'b1001: state_d = S9;
          4'b0000: state_d = S0;
          4'b1100: state_d = S12;
          4'b0100: state_d = S4;
          4'b0110: state_d = S6;
          4'b0111: state_d = S7;
          4'b1101: state_d = PAUSE1;
          default: state_d = S18;  // unimplemented opcodes act as NOP
        endcase
      end
      S0:        state_d = BEN ? S22 : S18;
      S4:        state_d = IR[11] ? S21 : S20;
      S6:        state_d = S25;
      S25:       if (wait_done) state_d = S27; else wait_cnt_d = wait_cnt_q + 3'd1;
      S7:        state_d = S23;
      S23:       state_d = S16;
      S16:       if (wait_done) state_d = S18; else wait_cnt_d = wait_cnt_q + 3'd1;
      PAUSE1:    if (Continue) state_d = PAUSE2;
      PAUSE2:    if (!Continue) state_d = S18;
      default:   state_d = S18;  // S1,S5,S9,S22,S12,S21,S20,S27 return to fetch
    endcase
  end

  // Moore output decode from the current state (and wait count for LD_MDR).
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX  = 2'b00; ADDR2MUX = 2'b00; ADDR1MUX = 1'b0;
    DRMUX  = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ALUK = 2'b00;
    MIO_EN = 1'b0; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      S18:      begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      S33, S25: begin Mem_CE = 1'b0; Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = wait_done; end
      S35:      begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32:      LD_BEN = 1'b1;
      S1:       begin SR2MUX = IR[5]; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S5:       begin SR2MUX = IR[5]; ALUK = 2'b01; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S9:       begin ALUK = 2'b10; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S22:      begin ADDR1MUX = 1'b1; ADDR2MUX = 2'b10; PCMUX = 2'b01; LD_PC = 1'b1; end
      S12, S20: begin ALUK = 2'b11; GateALU = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      S4:       begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S21:      begin ADDR1MUX = 1'b1; ADDR2MUX = 2'b11; PCMUX = 2'b01; LD_PC = 1'b1; end
      S6, S7:   begin ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      S27:      begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23:      begin SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      S16:      begin Mem_CE = 1'b0; Mem_WE = 1'b0; end
      PAUSE1:   LD_LED = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: builds the expected per-cycle control trace of
// each instruction (fetch, pause handshake, decode, execute) as a queue of
// steps, then replays it against the DUT cycle by cycle.
module tb_lc3_control_fsm;

  localparam int MW = 2;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux;
    logic addr1mux, drmux, sr1mux, sr2mux;
    logic [1:0] aluk;
    logic mio_en, mem_ce, mem_oe, mem_we;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       exp;
    logic [15:0] ir;
    logic        rst, run, cont, ben;
  } step_t;

  logic Clk = 1'b0, Reset, Run, Continue, BEN;
  logic [15:0] IR;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_CE, Mem_OE, Mem_WE;

  ctrl_t obs;
  step_t steps[$];
  string tags[$];
  logic [15:0] cur_ir;
  int checks = 0;
  int errors = 0;

  lc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX,
                ADDR1MUX, DRMUX, SR1MUX, SR2MUX, ALUK, MIO_EN, Mem_CE, Mem_OE, Mem_WE};

  function automatic ctrl_t idle();
    ctrl_t c = '0;
    c.mem_ce = 1'b1; c.mem_oe = 1'b1; c.mem_we = 1'b1;
    return c;
  endfunction

  // One SRAM read cycle; the MDR load happens on the last of MW cycles.
  function automatic ctrl_t rd(input int i);
    ctrl_t c = idle();
    c.mem_ce = 1'b0; c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = (i == MW - 1);
    return c;
  endfunction

  // Append one cycle; a negative input value means "don't care" and is randomised.
  task automatic push(input ctrl_t e, input string t, input int run_v = -1,
                      input int cont_v = -1, input int ben_v = -1, input bit rst_v = 1'b0);
    step_t s;
    s.exp  = e;
    s.ir   = cur_ir;
    s.rst  = rst_v;
    s.run  = (run_v  < 0) ? 1'($urandom) : 1'(run_v);
    s.cont = (cont_v < 0) ? 1'($urandom) : 1'(cont_v);
    s.ben  = (ben_v  < 0) ? 1'($urandom) : 1'(ben_v);
    steps.push_back(s);
    tags.push_back(t);
  endtask

  task automatic halted(input int k);
    repeat (k) push(idle(), "HALTED", 0);
    push(idle(), "HALTED_RUN", 1);
  endtask

  // Continue press then release, with random hold lengths on each side.
  task automatic handshake(input ctrl_t e1, input string t1, input ctrl_t e2, input string t2);
    int n = $urandom_range(0, 2);
    int m = $urandom_range(0, 2);
    repeat (n) push(e1, t1, -1, 0);
    push(e1, t1, -1, 1);
    repeat (m) push(e2, t2, -1, 1);
    push(e2, t2, -1, 0);
  endtask

  task automatic mem_read(input string t);
    for (int i = 0; i < MW; i++) push(rd(i), t);
  endtask

  // Expected trace of one instruction starting from the fetch state.
  task automatic instr(input logic [15:0] ir, input bit ben_v = 1'b0, input bit abort_s25 = 1'b0);
    ctrl_t w;
    cur_ir = ir;
    w = idle(); w.gate_pc = 1; w.ld_mar = 1; w.ld_pc = 1; push(w, "S18");
    mem_read("S33");
    w = idle(); w.gate_mdr = 1; w.ld_ir = 1; push(w, "S35");
    handshake(idle(), "PAUSE_IR1", idle(), "PAUSE_IR2");
    w = idle(); w.ld_ben = 1; push(w, "S32");
    case (ir[15:12])
      4'b0001, 4'b0101: begin
        w = idle(); w.sr2mux = ir[5]; w.aluk = (ir[15:12] == 4'b0101) ? 2'b01 : 2'b00;
        w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; push(w, "ADD_AND");
      end
      4'b1001: begin
        w = idle(); w.aluk = 2'b10; w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; push(w, "NOT");
      end
      4'b0000: begin
        push(idle(), "BR_S0", -1, -1, int'(ben_v));
        if (ben_v) begin
          w = idle(); w.addr1mux = 1; w.addr2mux = 2'b10; w.pcmux = 2'b01; w.ld_pc = 1; push(w, "S22");
        end
      end
      4'b1100: begin
        w = idle(); w.aluk = 2'b11; w.gate_alu = 1; w.pcmux = 2'b10; w.ld_pc = 1; push(w, "JMP");
      end
      4'b0100: begin
        w = idle(); w.gate_pc = 1; w.drmux = 1; w.ld_reg = 1; push(w, "JSR_S4");
        w = idle(); w.pcmux = ir[11] ? 2'b01 : 2'b10; w.ld_pc = 1;
        if (ir[11]) begin w.addr1mux = 1; w.addr2mux = 2'b11; end
        else begin w.aluk = 2'b11; w.gate_alu = 1; end
        push(w, "JSR_TARGET");
      end
      4'b0110, 4'b0111: begin
        w = idle(); w.addr2mux = 2'b01; w.gate_marmux = 1; w.ld_mar = 1; push(w, "ADDR_CALC");
        if (ir[12] == 1'b0) begin
          if (abort_s25) begin
            push(rd(0), "S25_RESET", -1, -1, -1, 1'b1);
            return;
          end
          mem_read("S25");
          w = idle(); w.gate_mdr = 1; w.ld_reg = 1; w.ld_cc = 1; push(w, "S27");
        end else begin
          w = idle(); w.sr1mux = 1; w.aluk = 2'b11; w.gate_alu = 1; w.ld_mdr = 1; push(w, "S23");
          w = idle(); w.mem_ce = 0; w.mem_we = 0;
          repeat (MW) push(w, "S16");
        end
      end
      4'b1101: begin
        w = idle(); w.ld_led = 1;
        handshake(w, "PAUSE1", idle(), "PAUSE2");
      end
      default: ;  // unimplemented opcode: straight back to fetch
    endcase
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; IR = '0; cur_ir = '0;
    repeat (3) @(posedge Clk);

    // Directed scenarios followed by a random instruction stream.
    halted(2);
    instr(16'h1262);
    instr(16'h0E05, 1'b1);
    instr(16'h0E05, 1'b0);
    instr(16'h7042);
    instr(16'h6042, 1'b0, 1'b1);
    halted(1);
    instr(16'hD00F);
    instr(16'h4800);
    instr(16'h4000);
    instr(16'h6042);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      instr(r, 1'($urandom));
    end

    for (int idx = 0; steps.size() > 0; idx++) begin
      step_t s;
      string t;
      s = steps.pop_front();
      t = tags.pop_front();
      @(negedge Clk);
      Reset = s.rst; Run = s.run; Continue = s.cont; BEN = s.ben; IR = s.ir;
      #1;
      checks++;
      assert (obs === s.exp) else begin
        errors++;
        $error("FAIL %s step %0d observed=%h expected=%h", t, idx, obs, s.exp);
      end
      checks++;
      assert (!(Mem_OE === 1'b0 && Mem_WE === 1'b0) &&
              $countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) else begin
        errors++;
        $error("FAIL bus_strobe_exclusive step %0d observed oe=%b we=%b gates=%b expected exclusive",
               idx, Mem_OE, Mem_WE, {GatePC, GateMDR, GateALU, GateMARMUX});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
